// File: rtl/pspin_boot_seq.sv
// Boot sequencer for the PsPIN clusters: holds the aux reset, staggers the per-cluster
// fetch enables, supervises the run phase with an optional timeout, and drains on stop.
module pspin_boot_seq #(
  parameter int unsigned NUM_CLUSTERS     = 2,
  parameter int unsigned RST_HOLD_CYCLES  = 16,
  parameter int unsigned FETCH_GAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [31:0]             timeout_limit,
  input  logic [NUM_CLUSTERS-1:0] cl_eoc_i,
  input  logic [NUM_CLUSTERS-1:0] cl_busy_i,
  output logic [NUM_CLUSTERS-1:0] cl_fetch_en_o,
  output logic                    aux_rst_o,
  output logic [2:0]              state_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  localparam int unsigned NC = NUM_CLUSTERS;
  localparam int unsigned KW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam int unsigned CW = 16;
  localparam int unsigned RW = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   run_q, run_d;
  logic [NC-1:0]   fetch_q, fetch_d;
  logic            aux_q, aux_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    k_d     = k_q;
    run_d   = run_q;
    fetch_d = fetch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RESET;
          hold_d  = CW'(RST_HOLD_CYCLES);
        end
      end
      ST_RESET: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (hold_q == CW'(1)) begin
          state_d = ST_ENABLE;
          k_d     = '0;
          gap_d   = CW'(FETCH_GAP_CYCLES);
          fetch_d = NC'(1);
        end else begin
          hold_d = hold_q - CW'(1);
        end
      end
      ST_ENABLE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (k_q == KW'(NUM_CLUSTERS - 1)) begin
          state_d = ST_RUN;
          run_d   = '0;
        end else if (gap_q == CW'(1)) begin
          k_d     = k_q + KW'(1);
          gap_d   = CW'(FETCH_GAP_CYCLES);
          fetch_d = fetch_q | (NC'(2) << k_q);
        end else begin
          gap_d = gap_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (&cl_eoc_i) begin
          state_d = ST_DONE;
        end else if ((timeout_limit != '0) && (run_q == timeout_limit - RW'(1))) begin
          state_d = ST_ERROR;
        end else if (run_q != '1) begin
          run_d = run_q + RW'(1);
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (start) begin
          state_d = ST_RESET;
          hold_d  = CW'(RST_HOLD_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (cl_busy_i == '0) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (start) begin
          state_d = ST_RESET;
          hold_d  = CW'(RST_HOLD_CYCLES);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fetch enables survive only through ENABLE, RUN and DONE
    if ((state_d == ST_IDLE) || (state_d == ST_RESET) ||
        (state_d == ST_DRAIN) || (state_d == ST_ERROR)) begin
      fetch_d = '0;
    end
    aux_d  = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_ERROR);
    done_d = (state_d == ST_DONE);
    tout_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      k_q     <= '0;
      run_q   <= '0;
      fetch_q <= '0;
      aux_q   <= 1'b1;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      k_q     <= k_d;
      run_q   <= run_d;
      fetch_q <= fetch_d;
      aux_q   <= aux_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign cl_fetch_en_o = fetch_q;
  assign aux_rst_o     = aux_q;
  assign state_o       = state_q;
  assign done_o        = done_q;
  assign timeout_o     = tout_q;

endmodule

// File: tb/tb_pspin_boot_seq.sv
// Bench for pspin_boot_seq: directed boot/complete/timeout/drain/reset scenarios with
// literal expectations, then random traffic against an elapsed-time behavioural model.
module tb_pspin_boot_seq;

  localparam int unsigned NC   = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned GAP  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   tlim = '0;
  logic [NC-1:0] eoc = '0;
  logic [NC-1:0] busy = '0;
  logic [NC-1:0] fetch_en;
  logic          aux_rst;
  logic [2:0]    state;
  logic          done;
  logic          tout;

  pspin_boot_seq #(
    .NUM_CLUSTERS    (NC),
    .RST_HOLD_CYCLES (HOLD),
    .FETCH_GAP_CYCLES(GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .timeout_limit(tlim),
    .cl_eoc_i     (eoc),
    .cl_busy_i    (busy),
    .cl_fetch_en_o(fetch_en),
    .aux_rst_o    (aux_rst),
    .state_o      (state),
    .done_o       (done),
    .timeout_o    (tout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: state plus cycle of entry; everything else follows from elapsed time
  localparam int M_IDLE = 0, M_RESET = 1, M_ENABLE = 2, M_RUN = 3,
                 M_DRAIN = 4, M_DONE = 5, M_ERROR = 6;
  int     m_state = M_IDLE;
  longint cyc = 0;
  longint m_enter = 0;
  longint el;
  int     nxt;

  function automatic int bits_at(input longint e);
    longint b;
    b = e / GAP + 1;
    if (b > NC) b = NC;
    return int'(b);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = M_IDLE;
      m_enter = cyc;
    end else begin
      el  = cyc - m_enter;
      nxt = m_state;
      case (m_state)
        M_IDLE:   if (start) nxt = M_RESET;
        M_RESET:  if (stop) nxt = M_DRAIN; else if (el == HOLD - 1) nxt = M_ENABLE;
        M_ENABLE: if (stop) nxt = M_DRAIN; else if (bits_at(el) == NC) nxt = M_RUN;
        M_RUN: begin
          if (stop) nxt = M_DRAIN;
          else if (eoc == {NC{1'b1}}) nxt = M_DONE;
          else if (tlim != 0 && el == longint'(tlim) - 1) nxt = M_ERROR;
        end
        M_DONE:   if (stop) nxt = M_DRAIN; else if (start) nxt = M_RESET;
        M_DRAIN:  if (busy == '0) nxt = M_IDLE;
        M_ERROR:  if (start) nxt = M_RESET;
        default:  nxt = M_IDLE;
      endcase
      if (nxt != m_state) m_enter = cyc + 1;
      m_state = nxt;
      cyc++;
    end
  end

  logic [NC-1:0] e_fetch;
  longint        el_n;

  always @(negedge clk) begin
    if (chk_en) begin
      el_n = cyc - m_enter;
      case (m_state)
        M_ENABLE:      e_fetch = NC'((1 << bits_at(el_n)) - 1);
        M_RUN, M_DONE: e_fetch = '1;
        default:       e_fetch = '0;
      endcase
      chk("m_state", 32'(state), 32'(m_state));
      chk("m_fetch", 32'(fetch_en), 32'(e_fetch));
      chk("m_aux", 32'(aux_rst),
          32'(m_state == M_IDLE || m_state == M_RESET || m_state == M_ERROR));
      chk("m_done", 32'(done), 32'(m_state == M_DONE));
      chk("m_tout", 32'(tout), 32'(m_state == M_ERROR));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_aux", 32'(aux_rst), 32'd1);
    chk("rst_fetch", 32'(fetch_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tout", 32'(tout), 32'd0);

    // Boot with defaults; start during cycle 0
    start = 1'b1; step(1); start = 1'b0;
    chk("boot_c1_state", 32'(state), 32'd1);
    step(15);
    chk("boot_c16_aux", 32'(aux_rst), 32'd1);
    step(1);
    chk("boot_c17_aux", 32'(aux_rst), 32'd0);
    chk("boot_c17_fetch", 32'(fetch_en), 32'b01);
    chk("boot_c17_state", 32'(state), 32'd2);
    step(3);
    chk("boot_c20_fetch", 32'(fetch_en), 32'b01);
    step(1);
    chk("boot_c21_fetch", 32'(fetch_en), 32'b11);
    step(1);
    chk("boot_c22_state", 32'(state), 32'd3);

    // Completion needs every cluster
    eoc = 2'b01; step(3);
    chk("eoc_partial_state", 32'(state), 32'd3);
    eoc = 2'b11; step(1); eoc = '0;
    chk("eoc_done", 32'(done), 32'd1);
    chk("eoc_done_state", 32'(state), 32'd5);
    chk("eoc_done_fetch", 32'(fetch_en), 32'b11);
    step(2);

    // start+stop together in DONE: stop wins
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("coll_drain_state", 32'(state), 32'd4);
    chk("coll_drain_fetch", 32'(fetch_en), 32'd0);
    step(1);
    chk("coll_idle_state", 32'(state), 32'd0);
    chk("coll_idle_aux", 32'(aux_rst), 32'd1);

    // Timeout after exactly 100 RUN cycles (RUN spans cycles 22..121)
    tlim = 32'd100;
    start = 1'b1; step(1); start = 1'b0;
    step(120);
    chk("to_c121_state", 32'(state), 32'd3);
    step(1);
    chk("to_state", 32'(state), 32'd6);
    chk("to_tout", 32'(tout), 32'd1);
    chk("to_fetch", 32'(fetch_en), 32'd0);
    chk("to_aux", 32'(aux_rst), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("to_stop_ignored", 32'(state), 32'd6);
    start = 1'b1; step(1); start = 1'b0;
    chk("to_restart_state", 32'(state), 32'd1);
    chk("to_restart_tout", 32'(tout), 32'd0);

    // eoc all-ones on the timeout-match cycle: DONE wins
    step(120);
    eoc = 2'b11; step(1); eoc = '0;
    chk("prio_state", 32'(state), 32'd5);
    chk("prio_tout", 32'(tout), 32'd0);

    // Drain: stop in RUN, busy held for 5 cycles
    tlim = '0;
    start = 1'b1; step(1); start = 1'b0;
    step(21);
    chk("drain_run", 32'(state), 32'd3);
    stop = 1'b1; busy = 2'b10; step(1); stop = 1'b0;
    chk("drain_entry_state", 32'(state), 32'd4);
    chk("drain_entry_fetch", 32'(fetch_en), 32'd0);
    chk("drain_entry_aux", 32'(aux_rst), 32'd0);
    step(4);
    chk("drain_5th_state", 32'(state), 32'd4);
    busy = '0; step(1);
    chk("drain_idle_state", 32'(state), 32'd0);
    chk("drain_idle_aux", 32'(aux_rst), 32'd1);

    // Asynchronous reset mid-ENABLE, between clock edges
    start = 1'b1; step(1); start = 1'b0;
    step(17);
    chk("ar_enable", 32'(state), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_aux", 32'(aux_rst), 32'd1);
    chk("ar_fetch", 32'(fetch_en), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_tout", 32'(tout), 32'd0);
    step(2);
    rst = 1'b0;

    // Random traffic against the model
    tlim = 32'd30;
    repeat (4000) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      eoc   = ($urandom_range(0, 39) == 0) ? '1 : (NC'($urandom) & ~NC'(1));
      busy  = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      if ($urandom_range(0, 49) == 0)
        tlim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      rst   = ($urandom_range(0, 799) == 0);
      step(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step(2);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pspin_boot_seq.md
PSPIN_BOOT_SEQ -- requirements
Module: pspin_boot_seq

Interface
REQ-001 Parameter NUM_CLUSTERS, default 2: number of PsPIN clusters sequenced.
REQ-002 Parameter RST_HOLD_CYCLES, default 16: cycles aux_rst_o stays high after start; legal range 1..65535.
REQ-003 Parameter FETCH_GAP_CYCLES, default 4: cycles between successive per-cluster fetch-enable assertions; legal range 1..65535.
REQ-004 clk  input  1  block clock; all ports synchronous to it.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 start  input  1  single-cycle boot/restart command.
REQ-007 stop  input  1  single-cycle halt command.
REQ-008 timeout_limit  input  32  RUN-state cycle limit; 0 disables the timeout.
REQ-009 cl_eoc_i  input  NUM_CLUSTERS  per-cluster end-of-computation, level.
REQ-010 cl_busy_i  input  NUM_CLUSTERS  per-cluster busy, level.
REQ-011 cl_fetch_en_o  output  NUM_CLUSTERS  per-cluster fetch enable, registered.
REQ-012 aux_rst_o  output  1  PsPIN reset, active-high, registered.
REQ-013 state_o  output  3  current state encoding (REQ-016).
REQ-014 done_o  output  1  high while in DONE.
REQ-015 timeout_o  output  1  high while in ERROR.

Function
REQ-016 FSM states and encodings: IDLE=0, RESET=1, ENABLE=2, RUN=3, DRAIN=4, DONE=5, ERROR=6; 7 unreachable, recovers to IDLE next cycle.
REQ-017 All outputs are registered; no combinational path from any input to any output.
REQ-018 IDLE: aux_rst_o=1, cl_fetch_en_o=0; start moves to RESET and loads the hold counter with RST_HOLD_CYCLES.
REQ-019 RESET: aux_rst_o=1 for exactly RST_HOLD_CYCLES cycles counted from RESET entry; the cycle after the last one, aux_rst_o=0 and state=ENABLE with cluster index k=0.
REQ-020 ENABLE: bit 0 of cl_fetch_en_o is set on the first ENABLE cycle; each further bit k is set FETCH_GAP_CYCLES cycles after bit k-1; once bit NUM_CLUSTERS-1 is set, the next cycle is RUN.
REQ-021 RUN: the 32-bit run counter clears on RUN entry and increments by 1 per RUN cycle, saturating at 0xFFFFFFFF.
REQ-022 RUN -> DONE when cl_eoc_i is all ones; takes priority over timeout in the same cycle.
REQ-023 RUN -> ERROR when timeout_limit!=0 and run counter == timeout_limit - 1 while cl_eoc_i is not all ones, i.e. after exactly timeout_limit RUN cycles.
REQ-024 timeout_limit is sampled on every RUN cycle; lowering it below the current count while running never triggers ERROR (equality compare only).
REQ-025 DONE: done_o=1, cl_fetch_en_o held, aux_rst_o=0; start -> RESET; stop -> DRAIN.
REQ-026 ERROR: timeout_o=1, cl_fetch_en_o=0, aux_rst_o=1; only start leaves ERROR (-> RESET); stop is ignored.
REQ-027 DRAIN: cl_fetch_en_o=0 on entry cycle, aux_rst_o=0; when cl_busy_i==0 the next state is IDLE (aux_rst_o=1 again).
REQ-028 stop in RESET, ENABLE, RUN or DONE moves to DRAIN next cycle; stop in IDLE, DRAIN or ERROR is ignored.
REQ-029 start in RESET, ENABLE, RUN or DRAIN is ignored; start and stop in the same cycle: stop wins where stop is legal, otherwise start handled per state.
REQ-030 Hold/gap counters are 16 bits; parameter 0 is illegal and is not checked.

Reset
REQ-031 While rst=1, and on the first cycle after release: state=IDLE, aux_rst_o=1, cl_fetch_en_o=0, done_o=0, timeout_o=0, all counters 0.
REQ-032 rst asserted in any state immediately (asynchronously) forces REQ-031 values; no drain is performed.

Verification
REQ-033 Boot: defaults, start at cycle 0, cl_eoc_i=0 -> aux_rst_o falls at cycle 17, fetch_en=01 at cycle 17, 11 at cycle 21, state_o=3 at cycle 22.
REQ-034 Completion: in RUN drive cl_eoc_i=01 then 11 -> state stays RUN on 01, done_o=1 one cycle after 11, fetch_en stays 11.
REQ-035 Timeout: timeout_limit=100, cl_eoc_i=0 -> ERROR after exactly 100 RUN cycles, timeout_o=1, fetch_en=0, aux_rst_o=1; start -> RESET, timeout_o=0.
REQ-036 Drain: stop in RUN with cl_busy_i=10 held 5 cycles -> fetch_en=0 next cycle, state DRAIN for 5 cycles, then IDLE with aux_rst_o=1.
REQ-037 Collisions: start+stop together in DONE -> DRAIN; eoc all-ones on same cycle as timeout match -> DONE, timeout_o=0.
REQ-038 Async reset: assert rst mid-ENABLE between clock edges -> outputs reach REQ-031 values before the next clk edge.
